pvr_vram_arbiter: RTL and testbench

Round-robin read arbiter that shares the single PVR VRAM read port between three burst requesters: the region-array walker (0), the ISP object/vertex parser (1) and the TSP texture fetcher (2). Each requester asks for a burst of consecutive 32-bit words. The arbiter grants one requester at a time and issues word addresses to VRAM under a wait-stall. It then routes returned data back to the owning requester and signals burst completion. It sits between the PVR front-end units and the VRAM controller.

---
 rtl/pvr_vram_arbiter_if.sv | 29 ++
 rtl/pvr_vram_arbiter.sv | 137 +++++++++++++
 tb/tb_pvr_vram_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pvr_vram_arbiter_if.sv
// Bus bundle between the PVR front-end requesters, the VRAM read arbiter and the VRAM controller.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface pvr_vram_arbiter_if #(
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 6
);
   logic [2:0]          req;
   logic [3*ADDR_W-1:0] req_addr;
   logic [3*LEN_W-1:0]  req_len;
   logic [2:0]          gnt;
   logic [2:0]          rd_valid;
   logic [31:0]         rd_data;
   logic [2:0]          done;
   logic                vram_rd;
   logic [ADDR_W-1:0]   vram_addr;
   logic                vram_wait;
   logic [31:0]         vram_din;
   logic                vram_din_valid;

   modport slave (
      input  req, req_addr, req_len, vram_wait, vram_din, vram_din_valid,
      output gnt, rd_valid, rd_data, done, vram_rd, vram_addr
   );

   modport master (
      output req, req_addr, req_len, vram_wait, vram_din, vram_din_valid,
      input  gnt, rd_valid, rd_data, done, vram_rd, vram_addr
   );
endinterface

// File: rtl/pvr_vram_arbiter.sv
// Round-robin burst read arbiter sharing the PVR VRAM read port between the region walker (0),
// the ISP parser (1) and the TSP texture fetcher (2); returns are routed to the burst owner.
module pvr_vram_arbiter #(
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 6
) (
   input  logic               clock,
   input  logic               reset,
   pvr_vram_arbiter_if.slave  bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [LEN_W:0]    CNT_ONE   = (LEN_W+1)'(1);
   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN_MSK = ~ADDR_W'(3);

   logic [1:0]        r_state;
   logic [1:0]        r_owner;
   logic [1:0]        r_last;
   logic [LEN_W:0]    r_issue_cnt;
   logic [LEN_W:0]    r_ret_cnt;
   logic [LEN_W-1:0]  r_len;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_gnt;

   logic [ADDR_W-1:0] w_req_addr [3];
   logic [LEN_W-1:0]  w_req_len  [3];
   logic [1:0]        w_pick;
   logic [2:0]        w_pick_oh;
   logic [2:0]        w_owner_oh;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [LEN_W-1:0]  w_sel_len;
   logic              w_any;
   logic              w_in_burst;
   logic              w_issue;
   logic              w_last_issue;
   logic [LEN_W:0]    w_words;
   logic              w_ret;
   logic              w_ret_done;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_req
         assign w_req_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
         assign w_req_len[gi]  = bus.req_len[gi*LEN_W +: LEN_W];
         assign w_pick_oh[gi]  = (w_pick == 2'(gi));
         assign w_owner_oh[gi] = (r_owner == 2'(gi));
      end
   endgenerate

   // Priority starts just after the previous owner and wraps 2 -> 0.
   always_comb begin
      w_pick = 2'd0;
      case (r_last)
         2'd0:    w_pick = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
         2'd1:    w_pick = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
         default: w_pick = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_comb begin
      w_sel_addr = w_req_addr[0];
      w_sel_len  = w_req_len[0];
      for (int k = 1; k < 3; k++) begin
         if (w_pick == 2'(k)) begin
            w_sel_addr = w_req_addr[k];
            w_sel_len  = w_req_len[k];
         end
      end
   end

   assign w_any        = |bus.req;
   assign w_in_burst   = (r_state == ST_BURST);
   assign w_issue      = w_in_burst && !bus.vram_wait;
   assign w_last_issue = (r_issue_cnt == {1'b0, r_len});
   assign w_words      = {1'b0, r_len} + CNT_ONE;

   // Returns beyond the burst length, or with no burst open, are discarded.
   assign w_ret      = bus.vram_din_valid && (r_state != ST_IDLE) && (r_ret_cnt <= {1'b0, r_len});
   assign w_ret_done = (r_ret_cnt == w_words);

   assign bus.vram_rd   = w_in_burst;
   assign bus.vram_addr = w_in_burst ? r_addr : '0;
   assign bus.gnt       = r_gnt;
   assign bus.rd_data   = bus.vram_din;
   assign bus.rd_valid  = w_ret ? w_owner_oh : 3'b000;
   assign bus.done      = ((r_state == ST_DRAIN) && w_ret_done) ? w_owner_oh : 3'b000;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_owner     <= 2'd0;
         r_last      <= 2'd2;
         r_issue_cnt <= '0;
         r_ret_cnt   <= '0;
         r_len       <= '0;
         r_addr      <= '0;
         r_gnt       <= 3'b000;
      end else begin
         r_gnt <= 3'b000;
         if (w_ret) begin
            r_ret_cnt <= r_ret_cnt + CNT_ONE;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_owner     <= w_pick;
                  r_addr      <= w_sel_addr & ALIGN_MSK;
                  r_len       <= w_sel_len;
                  r_issue_cnt <= '0;
                  r_ret_cnt   <= '0;
                  r_gnt       <= w_pick_oh;
                  r_state     <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (w_issue) begin
                  r_addr      <= r_addr + WORD_STEP;
                  r_issue_cnt <= r_issue_cnt + CNT_ONE;
                  if (w_last_issue) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // done is visible this cycle; the next cycle is IDLE and arbitrates again.
               if (w_ret_done) begin
                  r_last  <= r_owner;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pvr_vram_arbiter.sv
// Bench for pvr_vram_arbiter: directed burst table, round-robin and reset sequences,
// then random traffic checked against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_pvr_vram_arbiter;
   localparam int AW = 24;
   localparam int LW = 6;

   typedef struct {
      string          name;
      int             r;
      logic [AW-1:0]  addr;
      logic [LW-1:0]  len;
      int             lat;
      int             stall_at;
      int             stall_n;
      bit             stray;
      logic [AW-1:0]  exp_first;
      logic [AW-1:0]  exp_last;
      int             exp_words;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clock = ~clock;

   pvr_vram_arbiter_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

   pvr_vram_arbiter #(.ADDR_W(AW), .LEN_W(LW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] oh(input int n);
      logic [2:0] v;
      v = 3'b000;
      v[n] = 1'b1;
      return v;
   endfunction

   function automatic int rr_pick(input logic [2:0] r, input int last);
      for (int k = 1; k <= 3; k++) begin
         if (r[(last + k) % 3]) return (last + k) % 3;
      end
      return 0;
   endfunction

   task automatic drive_idle();
      bus.req            = 3'b000;
      bus.req_addr       = '0;
      bus.req_len        = '0;
      bus.vram_wait      = 1'b0;
      bus.vram_din       = '0;
      bus.vram_din_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      drive_idle();
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic run_burst(input vec_t v);
      int            issued = 0, returned = 0, stalled = 0, last_ret = -10;
      int            rq[$];
      logic [AW-1:0] exp_addr;
      logic [AW-1:0] last_addr = '0;
      logic [31:0]   cur_din;
      logic [2:0]    exp_rv, exp_dn;
      bit            stray_sent = 0, finished = 0;
      exp_addr = v.exp_first;
      @(posedge clock); #1;
      drive_idle();
      bus.req[v.r] = 1'b1;
      bus.req_addr[v.r*AW +: AW] = v.addr;
      bus.req_len[v.r*LW +: LW]  = v.len;
      @(negedge clock);
      chk({v.name, "/gnt_pre"}, 32'(bus.gnt), 32'(0));
      for (int c = 1; c < 400 && !finished; c++) begin
         @(posedge clock); #1;
         bus.req      = 3'b000;
         bus.req_addr = {3{AW'($urandom)}};
         bus.req_len  = {3{LW'($urandom)}};
         bus.vram_wait = (issued == v.stall_at) && (stalled < v.stall_n);
         bus.vram_din_valid = 1'b0;
         bus.vram_din = $urandom;
         if (rq.size() > 0 && rq[0] <= c) begin
            void'(rq.pop_front());
            bus.vram_din_valid = 1'b1;
         end else if (v.stray && returned == v.exp_words && !stray_sent) begin
            bus.vram_din_valid = 1'b1;
            stray_sent = 1;
         end
         cur_din = bus.vram_din;
         @(negedge clock);
         chk({v.name, "/gnt"}, 32'(bus.gnt), 32'((c == 1) ? oh(v.r) : 3'b000));
         chk({v.name, "/vram_rd"}, 32'(bus.vram_rd), 32'(issued < v.exp_words));
         if (bus.vram_rd) begin
            chk({v.name, "/vram_addr"}, 32'(bus.vram_addr), 32'(exp_addr));
            if (bus.vram_wait) begin
               stalled++;
            end else begin
               last_addr = bus.vram_addr;
               exp_addr  = exp_addr + AW'(4);
               issued++;
               rq.push_back(c + v.lat);
            end
         end
         exp_rv = (bus.vram_din_valid && returned < v.exp_words) ? oh(v.r) : 3'b000;
         chk({v.name, "/rd_valid"}, 32'(bus.rd_valid), 32'(exp_rv));
         if (exp_rv != 3'b000) begin
            chk({v.name, "/rd_data"}, bus.rd_data, cur_din);
            returned++;
            if (returned == v.exp_words) last_ret = c;
         end
         exp_dn = (returned == v.exp_words && c == last_ret + 1) ? oh(v.r) : 3'b000;
         chk({v.name, "/done"}, 32'(bus.done), 32'(exp_dn));
         if (bus.done != 3'b000) finished = 1;
      end
      chk({v.name, "/done_within_bound"}, 32'(finished), 32'(1));
      @(posedge clock); #1;
      drive_idle();
      @(negedge clock);
      chk({v.name, "/post_vram_rd"}, 32'(bus.vram_rd), 32'(0));
      chk({v.name, "/post_done"}, 32'(bus.done), 32'(0));
      chk({v.name, "/issues"}, 32'(issued), 32'(v.exp_words));
      chk({v.name, "/returns"}, 32'(returned), 32'(v.exp_words));
      chk({v.name, "/last_addr"}, 32'(last_addr), 32'(v.exp_last));
      chk({v.name, "/stall_cycles"}, 32'(stalled), 32'(v.stall_n));
      $display("burst %s: req %0d addr %06h len %0d -> %0d issues, %0d returns, last addr %06h",
               v.name, v.r, v.addr, v.len, issued, returned, last_addr);
   endtask

   task automatic run_round_robin();
      int gc[$], dc[$], rq[$];
      logic [2:0] go[$];
      int exp_order[4] = '{0, 1, 2, 0};
      do_reset();
      for (int c = 0; c < 300 && gc.size() < 5; c++) begin
         @(posedge clock); #1;
         bus.req      = 3'b111;
         bus.req_addr = {24'h003000, 24'h002000, 24'h001000};
         bus.req_len  = {3{6'd1}};
         bus.vram_wait = 1'b0;
         bus.vram_din_valid = 1'b0;
         bus.vram_din = $urandom;
         if (rq.size() > 0 && rq[0] <= c) begin
            void'(rq.pop_front());
            bus.vram_din_valid = 1'b1;
         end
         @(negedge clock);
         if (bus.gnt != 3'b000) begin
            gc.push_back(c);
            go.push_back(bus.gnt);
         end
         if (bus.done != 3'b000) dc.push_back(c);
         if (bus.vram_rd) rq.push_back(c + 1);
      end
      chk("rr/grant_count", 32'(gc.size() >= 4), 32'(1));
      for (int k = 0; k < 4 && k < go.size(); k++) begin
         chk($sformatf("rr/grant%0d", k), 32'(go[k]), 32'(oh(exp_order[k])));
      end
      for (int k = 0; k < 3 && k < dc.size() && k + 1 < gc.size(); k++) begin
         chk($sformatf("rr/done_to_gnt%0d", k), 32'(gc[k+1] - dc[k]), 32'(2));
      end
      $display("round robin: %0d grants, first at cycle %0d", gc.size(), (gc.size() > 0) ? gc[0] : -1);
      do_reset();
   endtask

   task automatic run_stray_reset();
      int issued = 0;
      vec_t fresh;
      do_reset();
      @(posedge clock); #1;
      drive_idle();
      bus.vram_din_valid = 1'b1;
      bus.vram_din = 32'hDEADBEEF;
      @(negedge clock);
      chk("stray/idle_rd_valid", 32'(bus.rd_valid), 32'(0));
      chk("stray/idle_done", 32'(bus.done), 32'(0));
      @(posedge clock); #1;
      bus.vram_din_valid = 1'b0;
      bus.req = 3'b100;
      bus.req_addr[2*AW +: AW] = 24'h00A000;
      bus.req_len[2*LW +: LW]  = 6'd7;
      for (int c = 0; c < 50 && issued < 2; c++) begin
         @(posedge clock); #1;
         bus.req = 3'b000;
         @(negedge clock);
         if (bus.vram_rd && !bus.vram_wait) issued++;
      end
      chk("stray/pre_reset_issues", 32'(issued), 32'(2));
      @(posedge clock); #1;
      reset = 1'b1;
      bus.vram_din_valid = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      bus.vram_din_valid = 1'b1;
      @(negedge clock);
      chk("reset/vram_rd", 32'(bus.vram_rd), 32'(0));
      chk("reset/vram_addr", 32'(bus.vram_addr), 32'(0));
      chk("reset/gnt", 32'(bus.gnt), 32'(0));
      chk("reset/rd_valid", 32'(bus.rd_valid), 32'(0));
      chk("reset/done", 32'(bus.done), 32'(0));
      @(posedge clock); #1;
      bus.vram_din_valid = 1'b1;
      @(negedge clock);
      chk("reset/late_rd_valid", 32'(bus.rd_valid), 32'(0));
      @(posedge clock); #1;
      bus.vram_din_valid = 1'b0;
      $display("stray/reset: %0d words issued before reset, late returns dropped", issued);
      fresh = '{"fresh", 1, 24'h00B004, 6'd1, 1, 0, 0, 1'b0, 24'h00B004, 24'h00B008, 2};
      run_burst(fresh);
   endtask

   task automatic run_random(input int ncyc);
      bit            pend[3];
      logic [AW-1:0] pa[3];
      logic [LW-1:0] pl[3];
      int            m_last = 2, owner = 0, words = 0, issued = 0, returned = 0;
      int            gnt_c = -10, done_due = -10, bursts = 0;
      bit            m_idle = 1, idle_now, exp_rd;
      logic [AW-1:0] exp_addr = '0;
      logic [2:0]    exp_rv;
      int            rq_t[$];
      logic [31:0]   rq_d[$];
      for (int r = 0; r < 3; r++) begin
         pend[r] = 0;
         pa[r] = '0;
         pl[r] = '0;
      end
      do_reset();
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clock); #1;
         for (int r = 0; r < 3; r++) begin
            if (!pend[r] && $urandom_range(0, 5) == 0) begin
               pend[r] = 1;
               pa[r] = AW'($urandom);
               pl[r] = ($urandom_range(0, 7) == 0) ? LW'($urandom) : LW'($urandom_range(0, 7));
            end
            bus.req[r] = pend[r];
            bus.req_addr[r*AW +: AW] = pa[r];
            bus.req_len[r*LW +: LW]  = pl[r];
         end
         bus.vram_wait = ($urandom_range(0, 3) == 0);
         bus.vram_din_valid = 1'b0;
         bus.vram_din = $urandom;
         if (rq_t.size() > 0 && rq_t[0] <= c) begin
            void'(rq_t.pop_front());
            bus.vram_din = rq_d.pop_front();
            bus.vram_din_valid = 1'b1;
         end
         @(negedge clock);
         idle_now = m_idle;
         chk("rand/gnt", 32'(bus.gnt), 32'((c == gnt_c) ? oh(owner) : 3'b000));
         exp_rd = !idle_now && c >= gnt_c && issued < words;
         chk("rand/vram_rd", 32'(bus.vram_rd), 32'(exp_rd));
         if (exp_rd) chk("rand/vram_addr", 32'(bus.vram_addr), 32'(exp_addr));
         if (bus.vram_rd && !bus.vram_wait) begin
            issued++;
            exp_addr = exp_addr + AW'(4);
            rq_t.push_back(c + $urandom_range(1, 4));
            rq_d.push_back($urandom);
         end
         exp_rv = (bus.vram_din_valid && !idle_now && returned < words) ? oh(owner) : 3'b000;
         chk("rand/rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
         if (exp_rv != 3'b000) begin
            chk("rand/rd_data", bus.rd_data, bus.vram_din);
            returned++;
            if (returned == words) done_due = c + 1;
         end
         chk("rand/done", 32'(bus.done), 32'((c == done_due) ? oh(owner) : 3'b000));
         if (c == done_due) begin
            m_last = owner;
            m_idle = 1;
            bursts++;
            $display("rand burst %0d: owner %0d, %0d words, done at cycle %0d", bursts, owner, words, c);
         end
         if (idle_now && bus.req != 3'b000) begin
            owner    = rr_pick(bus.req, m_last);
            m_idle   = 0;
            gnt_c    = c + 1;
            issued   = 0;
            returned = 0;
            words    = int'(pl[owner]) + 1;
            exp_addr = pa[owner] & ~AW'(3);
            pend[owner] = 0;
            done_due = -10;
         end
      end
      chk("rand/some_bursts", 32'(bursts > 10), 32'(1));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[4];
      vt[0] = '{"single", 1, 24'h00408C, 6'd3,  2, 0, 0, 1'b0, 24'h00408C, 24'h004098, 4};
      vt[1] = '{"stall",  0, 24'h001000, 6'd5,  1, 2, 3, 1'b0, 24'h001000, 24'h001014, 6};
      vt[2] = '{"wrap",   2, 24'hFFFFFA, 6'd2,  3, 0, 0, 1'b0, 24'hFFFFF8, 24'h000000, 3};
      vt[3] = '{"maxlen", 0, 24'h020000, 6'd63, 2, 0, 0, 1'b1, 24'h020000, 24'h0200FC, 64};
      drive_idle();
      do_reset();
      @(negedge clock);
      chk("init/vram_rd", 32'(bus.vram_rd), 32'(0));
      chk("init/vram_addr", 32'(bus.vram_addr), 32'(0));
      chk("init/gnt", 32'(bus.gnt), 32'(0));
      chk("init/rd_valid", 32'(bus.rd_valid), 32'(0));
      chk("init/done", 32'(bus.done), 32'(0));
      for (int i = 0; i < 4; i++) run_burst(vt[i]);
      run_round_robin();
      run_stray_reset();
      run_random(3000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
